singles_arbiter: RTL and testbench

- Merges the validated single-event words from NBLK detector front-end blocks into one output stream for the link serializer.
- Uses round-robin arbitration over the per-block valid/ready handshakes.
- Generates time-tag words on each `period_done` pulse. A tag is held back while any block asserts stall, so every event that straddles a period boundary is emitted before the tag.
- Sits between the detector front-end instances and the frontend transmit path.

---
 rtl/singles_arbiter.sv | 157 +++++++++++++++
 tb/tb_singles_arbiter.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/singles_arbiter.sv
// singles_arbiter: merges per-block single-event words into one output
// stream with round-robin arbitration, and inserts time-tag words on each
// period_done. A pending tag is held back while any block reports stall, so
// events that straddle a period boundary reach the link ahead of the tag.
module singles_arbiter #(
   parameter int NBLK      = 4,
   parameter int DATA_BITS = 128
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NBLK-1:0]           in_valid,
   input  logic [NBLK*DATA_BITS-1:0] in_data,
   input  logic [NBLK-1:0]           in_stall,
   output logic [NBLK-1:0]           in_ready,
   input  logic                      period_done,
   output logic                      out_valid,
   output logic [DATA_BITS-1:0]      out_data,
   input  logic                      out_ready,
   output logic [47:0]               tt_count,
   output logic                      tt_overrun,
   output logic [15:0]               tt_lost
);

   localparam int              PTR_W  = (NBLK > 1) ? $clog2(NBLK) : 1;
   localparam logic [PTR_W:0]  NBLK_W = (PTR_W+1)'(NBLK);
   localparam logic [PTR_W:0]  ONE_W  = (PTR_W+1)'(1);

   // state
   logic                 out_valid_q, out_valid_d;
   logic [DATA_BITS-1:0] out_data_q,  out_data_d;
   logic [PTR_W-1:0]     ptr_q,       ptr_d;
   logic                 pend_q,      pend_d;
   logic [47:0]          tag_q,       tag_d;
   logic [47:0]          cnt_q,       cnt_d;
   logic                 ovr_q,       ovr_d;
   logic [15:0]          lost_q,      lost_d;

   // arbitration wires
   logic                 slot_free;
   logic                 tag_elig;
   logic                 load_tag;
   logic                 load_blk;
   logic                 any_valid;
   logic [2*NBLK-1:0]    vld_dbl;
   logic [NBLK-1:0]      vld_rot;
   logic [PTR_W-1:0]     gnt_off;
   logic [PTR_W:0]       gnt_sum;
   logic [PTR_W-1:0]     gnt_idx;
   logic [PTR_W:0]       gnt_nxt;
   logic [DATA_BITS-1:0] gnt_data;
   logic [DATA_BITS-1:0] tag_word;
   logic [NBLK-1:0]      ready_raw;

   // Round-robin search: rotate valids so the pointer sits at bit 0, take the
   // lowest set bit, then map the offset back to an absolute block index.
   always_comb begin
      vld_dbl   = {in_valid, in_valid} >> ptr_q;
      vld_rot   = vld_dbl[NBLK-1:0];
      any_valid = |in_valid;
      gnt_off   = '0;
      for (int i = NBLK-1; i >= 0; i--) begin
         if (vld_rot[i]) gnt_off = PTR_W'(i);
      end
      gnt_sum = {1'b0, ptr_q} + {1'b0, gnt_off};
      if (gnt_sum >= NBLK_W) gnt_sum = gnt_sum - NBLK_W;
      gnt_idx = gnt_sum[PTR_W-1:0];
      gnt_nxt = {1'b0, gnt_idx} + ONE_W;
      if (gnt_nxt >= NBLK_W) gnt_nxt = '0;
   end

   // Select the granted block's word.
   always_comb begin
      gnt_data = '0;
      for (int k = 0; k < NBLK; k++) begin
         if (gnt_idx == PTR_W'(k)) gnt_data = in_data[k*DATA_BITS +: DATA_BITS];
      end
   end

   // Load decision: an eligible tag always beats block traffic.
   always_comb begin
      slot_free = ~out_valid_q | out_ready;
      tag_elig  = pend_q & ~(|in_stall);
      load_tag  = slot_free & tag_elig;
      load_blk  = slot_free & ~tag_elig & any_valid;
      tag_word  = {5'b11111, 1'b0, {(DATA_BITS-54){1'b0}}, tag_q};
      ready_raw = '0;
      if (load_blk) ready_raw = NBLK'(1) << gnt_idx;
   end

   // Accept is gated by reset so no block sees a handshake while held in reset.
   assign in_ready = ready_raw & {NBLK{rst_n}};

   // Output register and round-robin pointer.
   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      ptr_d       = ptr_q;
      if (load_tag) begin
         out_valid_d = 1'b1;
         out_data_d  = tag_word;
      end else if (load_blk) begin
         out_valid_d = 1'b1;
         out_data_d  = gnt_data;
         ptr_d       = gnt_nxt[PTR_W-1:0];
      end else if (slot_free) begin
         out_valid_d = 1'b0;
      end
   end

   // Period counter and tag bookkeeping. A tag loaded in the same cycle as a
   // new period_done makes room for the new one, so that is not an overrun.
   always_comb begin
      cnt_d  = cnt_q + {47'd0, period_done};
      pend_d = pend_q & ~load_tag;
      tag_d  = tag_q;
      ovr_d  = ovr_q;
      lost_d = lost_q;
      if (period_done) begin
         pend_d = 1'b1;
         tag_d  = cnt_d;
         if (pend_q && !load_tag) begin
            ovr_d = 1'b1;
            if (lost_q != 16'hFFFF) lost_d = lost_q + 16'd1;
         end
      end
   end

   // State registers; reset also discards any word sitting in the output slot.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         ptr_q       <= '0;
         pend_q      <= 1'b0;
         tag_q       <= '0;
         cnt_q       <= '0;
         ovr_q       <= 1'b0;
         lost_q      <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         ptr_q       <= ptr_d;
         pend_q      <= pend_d;
         tag_q       <= tag_d;
         cnt_q       <= cnt_d;
         ovr_q       <= ovr_d;
         lost_q      <= lost_d;
      end
   end

   assign out_valid  = out_valid_q;
   assign out_data   = out_data_q;
   assign tt_count   = cnt_q;
   assign tt_overrun = ovr_q;
   assign tt_lost    = lost_q;

endmodule

// File: tb/tb_singles_arbiter.sv
// Bench for singles_arbiter: reset checks, a vector table, directed corner
// sequences and a randomized run against a behavioural model.
module tb_singles_arbiter;

   localparam int N  = 4;
   localparam int DW = 128;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [N-1:0]      in_valid;
   logic [N*DW-1:0]   in_data;
   logic [N-1:0]      in_stall;
   logic [N-1:0]      in_ready;
   logic              period_done;
   logic              out_valid;
   logic [DW-1:0]     out_data;
   logic              out_ready;
   logic [47:0]       tt_count;
   logic              tt_overrun;
   logic [15:0]       tt_lost;

   singles_arbiter #(.NBLK(N), .DATA_BITS(DW)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_data(in_data), .in_stall(in_stall), .in_ready(in_ready),
      .period_done(period_done),
      .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
      .tt_count(tt_count), .tt_overrun(tt_overrun), .tt_lost(tt_lost)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   logic [N-1:0] rdy_s;

   task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%h want=%h", nm, act, exp);
      end
   endtask

   function automatic logic [DW-1:0] wd(input int k, input int n);
      return {8'(k), 24'h0, 32'(n), 64'hC0DE_0000_0000_0000 | 64'(k)};
   endfunction

   function automatic logic [DW-1:0] tagw(input logic [47:0] v);
      return {5'h1F, 1'b0, 74'd0, v};
   endfunction

   task automatic set_data(input int k, input logic [DW-1:0] d);
      in_data[k*DW +: DW] = d;
   endtask

   // one clock: drive at posedge+1, sample ready combinationally, land at next posedge+1
   task automatic step(input logic [N-1:0] v, input logic [N-1:0] st, input logic pd, input logic ordy);
      in_valid = v; in_stall = st; period_done = pd; out_ready = ordy;
      #1 rdy_s = in_ready;
      @(posedge clk);
      #1;
   endtask

   // ---------------- behavioural model ----------------
   logic          m_ov;
   logic [DW-1:0] m_od;
   logic          m_pend;
   logic [47:0]   m_tag;
   logic [47:0]   m_cnt;
   logic          m_ovr;
   logic [15:0]   m_lost;
   int            m_ptr;

   task automatic model_reset();
      m_ov = 0; m_od = '0; m_pend = 0; m_tag = '0; m_cnt = '0;
      m_ovr = 0; m_lost = '0; m_ptr = 0;
   endtask

   task automatic model_pick(output logic tag_ld, output int g);
      tag_ld = 0; g = -1;
      if (!m_ov || out_ready) begin
         if (m_pend && in_stall == '0) tag_ld = 1;
         else begin
            for (int k = 0; k < N; k++) begin
               int b;
               b = (m_ptr + k) % N;
               if (g < 0 && in_valid[b]) g = b;
            end
         end
      end
   endtask

   task automatic model_clock();
      logic tl; int g; logic was;
      model_pick(tl, g);
      was = m_pend;
      if (tl) begin
         m_ov = 1; m_od = tagw(m_tag); m_pend = 0;
      end else if (g >= 0) begin
         m_ov = 1; m_od = in_data[g*DW +: DW]; m_ptr = (g + 1) % N;
      end else if (!m_ov || out_ready) begin
         m_ov = 0;
      end
      if (period_done) begin
         m_cnt = m_cnt + 48'd1;
         if (was && !tl) begin
            m_ovr = 1;
            if (m_lost != 16'hFFFF) m_lost = m_lost + 16'd1;
         end
         m_pend = 1;
         m_tag  = m_cnt;
      end
   endtask

   task automatic do_reset();
      rst_n = 0; in_valid = '0; in_stall = '0; period_done = 0; out_ready = 1;
      for (int k = 0; k < N; k++) set_data(k, wd(k, 0));
      repeat (2) @(posedge clk);
      #1 rst_n = 1;
      model_reset();
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic [N-1:0]  v;
      logic [N-1:0]  st;
      logic          pd;
      logic          ordy;
      logic [N-1:0]  rdy;
      logic          ov;
      logic [DW-1:0] od;
      logic [47:0]   cnt;
   } vec_t;

   vec_t tbl[8];

   initial begin
      // round robin over all-valid blocks, then a tag with idle inputs
      tbl[0] = '{4'hF, 4'h0, 1'b0, 1'b1, 4'b0001, 1'b1, wd(0,0), 48'd0};
      tbl[1] = '{4'hF, 4'h0, 1'b0, 1'b1, 4'b0010, 1'b1, wd(1,0), 48'd0};
      tbl[2] = '{4'hF, 4'h0, 1'b0, 1'b1, 4'b0100, 1'b1, wd(2,0), 48'd0};
      tbl[3] = '{4'hF, 4'h0, 1'b0, 1'b1, 4'b1000, 1'b1, wd(3,0), 48'd0};
      tbl[4] = '{4'hF, 4'h0, 1'b0, 1'b1, 4'b0001, 1'b1, wd(0,0), 48'd0};
      tbl[5] = '{4'h0, 4'h0, 1'b1, 1'b1, 4'b0000, 1'b0, '0,      48'd1};
      tbl[6] = '{4'h0, 4'h0, 1'b0, 1'b1, 4'b0000, 1'b1, tagw(48'd1), 48'd1};
      tbl[7] = '{4'h0, 4'h0, 1'b0, 1'b1, 4'b0000, 1'b0, '0,      48'd1};

      // reset state, with all blocks requesting
      rst_n = 0; in_valid = 4'hF; in_stall = '0; period_done = 0; out_ready = 1;
      for (int k = 0; k < N; k++) set_data(k, wd(k, 0));
      #3;
      chk("rst_ready",   in_ready,   '0);
      chk("rst_ovalid",  out_valid,  '0);
      chk("rst_odata",   out_data,   '0);
      chk("rst_count",   tt_count,   '0);
      chk("rst_overrun", tt_overrun, '0);
      chk("rst_lost",    tt_lost,    '0);
      do_reset();

      for (int i = 0; i < 8; i++) begin
         step(tbl[i].v, tbl[i].st, tbl[i].pd, tbl[i].ordy);
         chk($sformatf("tbl%0d_ready", i), rdy_s, tbl[i].rdy);
         chk($sformatf("tbl%0d_ovalid", i), out_valid, tbl[i].ov);
         if (tbl[i].ov) chk($sformatf("tbl%0d_odata", i), out_data, tbl[i].od);
         chk($sformatf("tbl%0d_count", i), tt_count, tbl[i].cnt);
      end

      // stall holds the tag until the straddling event is out
      do_reset();
      set_data(2, wd(2, 7));
      step(4'h0, 4'b0100, 1'b1, 1'b1);
      chk("st_pd_ovalid", out_valid, 1'b0);
      chk("st_pd_count", tt_count, 48'd1);
      for (int i = 0; i < 10; i++) begin
         step(4'h0, 4'b0100, 1'b0, 1'b1);
         chk($sformatf("st_hold%0d", i), out_valid, 1'b0);
      end
      step(4'b0100, 4'b0100, 1'b0, 1'b1);
      chk("st_ack_ready", rdy_s, 4'b0100);
      chk("st_evt_ovalid", out_valid, 1'b1);
      chk("st_evt_odata", out_data, wd(2, 7));
      step(4'h0, 4'h0, 1'b0, 1'b1);
      chk("st_tag_ovalid", out_valid, 1'b1);
      chk("st_tag_odata", out_data, tagw(48'd1));
      step(4'h0, 4'h0, 1'b0, 1'b1);
      chk("st_after_ovalid", out_valid, 1'b0);

      // overrun while the tag is held by stall
      do_reset();
      step(4'h0, 4'b0010, 1'b1, 1'b1);
      repeat (3) step(4'h0, 4'b0010, 1'b0, 1'b1);
      chk("ov_pre_overrun", tt_overrun, 1'b0);
      step(4'h0, 4'b0010, 1'b1, 1'b1);
      chk("ov_overrun", tt_overrun, 1'b1);
      chk("ov_lost", tt_lost, 16'd1);
      chk("ov_count", tt_count, 48'd2);
      chk("ov_ovalid", out_valid, 1'b0);
      step(4'h0, 4'h0, 1'b0, 1'b1);
      chk("ov_tag_ovalid", out_valid, 1'b1);
      chk("ov_tag_odata", out_data, tagw(48'd2));
      step(4'h0, 4'h0, 1'b0, 1'b1);
      chk("ov_single_tag", out_valid, 1'b0);
      chk("ov_sticky", tt_overrun, 1'b1);

      // backpressure: slot frozen, no accepts, nothing lost on release
      do_reset();
      set_data(0, wd(0, 1)); set_data(2, wd(2, 1));
      step(4'b0101, 4'h0, 1'b0, 1'b0);
      chk("bp_first_ready", rdy_s, 4'b0001);
      chk("bp_first_odata", out_data, wd(0, 1));
      set_data(0, wd(0, 2));
      for (int i = 0; i < 5; i++) begin
         step(4'b0101, 4'h0, 1'b0, 1'b0);
         chk($sformatf("bp_hold%0d_ready", i), rdy_s, 4'b0000);
         chk($sformatf("bp_hold%0d_ovalid", i), out_valid, 1'b1);
         chk($sformatf("bp_hold%0d_odata", i), out_data, wd(0, 1));
      end
      step(4'b0101, 4'h0, 1'b0, 1'b1);
      chk("bp_rel_ready", rdy_s, 4'b0100);
      chk("bp_rel_odata", out_data, wd(2, 1));
      step(4'b0001, 4'h0, 1'b0, 1'b1);
      chk("bp_rel2_ready", rdy_s, 4'b0001);
      chk("bp_rel2_odata", out_data, wd(0, 2));
      step(4'h0, 4'h0, 1'b0, 1'b1);
      chk("bp_drain", out_valid, 1'b0);

      // asynchronous reset with a word in the slot
      do_reset();
      step(4'h0, 4'h0, 1'b1, 1'b1);
      step(4'h0, 4'h0, 1'b0, 1'b1);
      step(4'hF, 4'h0, 1'b0, 1'b0);
      chk("ar_pre_ovalid", out_valid, 1'b1);
      chk("ar_pre_count", tt_count, 48'd1);
      #2 rst_n = 0;
      #1;
      chk("ar_ovalid", out_valid, 1'b0);
      chk("ar_ready", in_ready, 4'b0000);
      chk("ar_count", tt_count, 48'd0);
      @(posedge clk); @(posedge clk);
      #1 rst_n = 1;
      model_reset();
      step(4'hF, 4'h0, 1'b0, 1'b1);
      chk("ar_restart_ready", rdy_s, 4'b0001);
      chk("ar_restart_odata", out_data, wd(0, 0));

      // randomized traffic against the model
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         logic tl; int g; logic [N-1:0] er;
         in_valid    = N'($urandom);
         for (int k = 0; k < N; k++) begin
            in_stall[k] = ($urandom_range(0, 7) == 0);
            set_data(k, {$urandom, $urandom, $urandom, $urandom});
         end
         period_done = ($urandom_range(0, 5) == 0);
         out_ready   = ($urandom_range(0, 3) != 0);
         #1;
         model_pick(tl, g);
         er = (g >= 0) ? N'(1) << g : '0;
         chk("rnd_ready", in_ready, er);
         @(posedge clk);
         #1;
         model_clock();
         chk("rnd_ovalid", out_valid, m_ov);
         if (m_ov) chk("rnd_odata", out_data, m_od);
         chk("rnd_count", tt_count, m_cnt);
         chk("rnd_overrun", tt_overrun, m_ovr);
         chk("rnd_lost", tt_lost, m_lost);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
